// File: rtl/block_freq_tester.sv
// NIST monobit and block-frequency tests run side by side on one serial bit stream.
// A run collects N = 2^N_LOG2 bits, folds in the final block, then reports |S|, chi_sum and pass flags.
module block_freq_tester #(
  parameter int N_LOG2 = 7,
  parameter int M_LOG2 = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [N_LOG2:0]          thr_s,
  input  logic [N_LOG2+M_LOG2:0]   thr_chi,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  output logic                     bit_ready,
  output logic                     busy,
  output logic                     done,
  output logic [N_LOG2:0]          s_abs,
  output logic [N_LOG2+M_LOG2:0]   chi_sum,
  output logic                     pass_mono,
  output logic                     pass_block,
  output logic [1:0]               dbg_state_o
);

  localparam int SW = N_LOG2 + 2;          // signed running sum S
  localparam int CW = N_LOG2 + M_LOG2 + 1; // chi accumulator
  localparam int OW = M_LOG2 + 1;          // ones-in-block counter, also |dev|
  localparam int DW = M_LOG2 + 2;          // signed dev in [-M, M]
  localparam int M  = 1 << M_LOG2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2,
    EVAL    = 2'd3
  } state_t;

  // Handshake: a bit transfers on every rising edge where bit_valid && bit_ready.
  // bit_ready is high only in COLLECT; start on the same edge takes priority and
  // the offered bit is discarded.

  state_t            state_q;
  logic [SW-1:0]     s_q;
  logic [N_LOG2-1:0] cnt_q;
  logic [OW-1:0]     ones_q;
  logic [DW-1:0]     dev_q;
  logic              dev_vld_q;
  logic [CW-1:0]     chi_q;
  logic [1:0]        mode_q;
  logic [N_LOG2:0]   thr_s_q;
  logic [CW-1:0]     thr_chi_q;
  logic              done_q;
  logic [N_LOG2:0]   s_abs_q;
  logic [CW-1:0]     chi_sum_q;
  logic              pass_mono_q;
  logic              pass_block_q;

  logic [SW-1:0]     s_d;
  logic [OW-1:0]     ones_d;
  logic [DW:0]       dev_wide;
  logic [DW-1:0]     dev_d;
  logic [DW-1:0]     dev_neg;
  logic [OW-1:0]     dev_abs;
  logic [2*OW-1:0]   dev_sq;
  logic [CW-1:0]     chi_d;
  logic [SW-1:0]     s_neg;
  logic [N_LOG2:0]   s_mag;
  logic              blk_end;
  logic              last_bit;
  logic [1:0]        mode_eff;

  always_comb begin
    s_d      = s_q + (bit_in ? SW'(1) : {SW{1'b1}});
    ones_d   = ones_q + OW'(bit_in);
    dev_wide = {1'b0, ones_d, 1'b0} - (DW+1)'(M);
    dev_d    = dev_wide[DW-1:0];
    dev_neg  = -dev_q;
    dev_abs  = dev_q[DW-1] ? dev_neg[OW-1:0] : dev_q[OW-1:0];
    dev_sq   = dev_abs * dev_abs;
    chi_d    = chi_q + CW'(dev_sq);
    s_neg    = -s_q;
    s_mag    = s_q[SW-1] ? s_neg[N_LOG2:0] : s_q[N_LOG2:0];
    blk_end  = &cnt_q[M_LOG2-1:0];
    last_bit = &cnt_q;
    mode_eff = (mode == 2'b00) ? 2'b11 : mode;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      s_q          <= '0;
      cnt_q        <= '0;
      ones_q       <= '0;
      dev_q        <= '0;
      dev_vld_q    <= 1'b0;
      chi_q        <= '0;
      mode_q       <= '0;
      thr_s_q      <= '0;
      thr_chi_q    <= '0;
      done_q       <= 1'b0;
      s_abs_q      <= '0;
      chi_sum_q    <= '0;
      pass_mono_q  <= 1'b0;
      pass_block_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      dev_vld_q <= 1'b0;
      // A completed block's dev is squared into chi one cycle after it is captured.
      if (dev_vld_q) chi_q <= chi_d;
      if (start) begin
        state_q   <= COLLECT;
        s_q       <= '0;
        cnt_q     <= '0;
        ones_q    <= '0;
        dev_q     <= '0;
        chi_q     <= '0;
        mode_q    <= mode_eff;
        thr_s_q   <= thr_s;
        thr_chi_q <= thr_chi;
      end else begin
        case (state_q)
          COLLECT: begin
            if (bit_valid) begin
              s_q   <= s_d;
              cnt_q <= cnt_q + 1'b1;
              if (blk_end) begin
                dev_q     <= dev_d;
                dev_vld_q <= 1'b1;
                ones_q    <= '0;
              end else begin
                ones_q <= ones_d;
              end
              if (last_bit) state_q <= FLUSH;
            end
          end
          FLUSH: state_q <= EVAL;
          EVAL: begin
            s_abs_q      <= mode_q[0] ? s_mag : '0;
            pass_mono_q  <= mode_q[0] && (s_mag <= thr_s_q);
            chi_sum_q    <= mode_q[1] ? chi_q : '0;
            pass_block_q <= mode_q[1] && (chi_q <= thr_chi_q);
            done_q       <= 1'b1;
            state_q      <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bit_ready   = (state_q == COLLECT);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign s_abs       = s_abs_q;
  assign chi_sum     = chi_sum_q;
  assign pass_mono   = pass_mono_q;
  assign pass_block  = pass_block_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_block_freq_tester.sv
// Directed bench for block_freq_tester: table of full runs plus abort and reset sequences.
module tb_block_freq_tester;

  localparam int N_LOG2 = 7;
  localparam int M_LOG2 = 3;
  localparam int N      = 1 << N_LOG2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic [1:0]             mode = 2'b11;
  logic [N_LOG2:0]        thr_s = '0;
  logic [N_LOG2+M_LOG2:0] thr_chi = '0;
  logic                   bit_in = 1'b0;
  logic                   bit_valid = 1'b0;
  logic                   bit_ready, busy, done, pass_mono, pass_block;
  logic [N_LOG2:0]        s_abs;
  logic [N_LOG2+M_LOG2:0] chi_sum;
  logic [1:0]             dbg_state;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  block_freq_tester #(.N_LOG2(N_LOG2), .M_LOG2(M_LOG2)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .thr_s(thr_s),
    .thr_chi(thr_chi), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .busy(busy), .done(done), .s_abs(s_abs),
    .chi_sum(chi_sum), .pass_mono(pass_mono), .pass_block(pass_block),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  typedef struct {
    int       kind;
    logic [1:0] mode;
    int       thr_s;
    int       thr_chi;
    int       gaps;
    int       exp_s;
    int       exp_chi;
    int       exp_pm;
    int       exp_pb;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind 0: 1010..., 1: all ones, 2: 8 ones / 8 zeros, 3: 66 ones then 62 zeros
  function automatic logic gen_bit(input int kind, input int i);
    case (kind)
      0:       return (i % 2) == 0;
      1:       return 1'b1;
      2:       return ((i / 8) % 2) == 0;
      default: return i < 66;
    endcase
  endfunction

  task automatic do_start(input logic [1:0] m, input int ts, input int tc);
    mode    = m;
    thr_s   = ts[N_LOG2:0];
    thr_chi = tc[N_LOG2+M_LOG2:0];
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic feed(input int kind, input int n, input int gaps_max);
    for (int i = 0; i < n; i++) begin
      if (gaps_max > 0) repeat ($urandom_range(0, gaps_max)) tick();
      bit_in    = gen_bit(kind, i);
      bit_valid = 1'b1;
      tick();
      bit_valid = 1'b0;
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int k;
    v = vecs[idx];
    do_start(v.mode, v.thr_s, v.thr_chi);
    feed(v.kind, N, v.gaps);
    check($sformatf("v%0d_ready_after_last", idx), bit_ready, 0);
    check($sformatf("v%0d_busy_after_last", idx), busy, 1);
    k = 0;
    while (!done && k < 10) begin
      tick();
      k++;
      if (k == 1) check($sformatf("v%0d_busy_flush", idx), busy, 1);
    end
    check($sformatf("v%0d_done_latency", idx), k, 2);
    check($sformatf("v%0d_s_abs", idx), s_abs, v.exp_s);
    check($sformatf("v%0d_chi_sum", idx), chi_sum, v.exp_chi);
    check($sformatf("v%0d_pass_mono", idx), pass_mono, v.exp_pm);
    check($sformatf("v%0d_pass_block", idx), pass_block, v.exp_pb);
    check($sformatf("v%0d_busy_at_done", idx), busy, 0);
    tick();
    check($sformatf("v%0d_done_one_cycle", idx), done, 0);
  endtask

  initial begin
    int base;
    //        kind mode   ts  tc    gaps s    chi   pm pb
    vecs[0] = '{0, 2'b11, 20, 100,  0,   0,   0,    1, 1};
    vecs[1] = '{1, 2'b11, 20, 100,  0,   128, 1024, 0, 0};
    vecs[2] = '{2, 2'b11, 20, 100,  0,   0,   1024, 1, 0};
    vecs[3] = '{0, 2'b11, 20, 100,  5,   0,   0,    1, 1};
    vecs[4] = '{3, 2'b11, 4,  100,  0,   4,   976,  1, 0};
    vecs[5] = '{3, 2'b11, 3,  976,  0,   4,   976,  0, 1};
    vecs[6] = '{0, 2'b01, 20, 100,  0,   0,   0,    1, 0};
    vecs[7] = '{1, 2'b00, 20, 100,  0,   128, 1024, 0, 0};
    vecs[8] = '{1, 2'b10, 20, 1024, 0,   0,   1024, 0, 1};

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", bit_ready, 0);
    check("rst_s_abs", s_abs, 0);
    check("rst_chi_sum", chi_sum, 0);
    check("rst_pass", {pass_mono, pass_block}, 0);

    for (int i = 0; i < 9; i++) run_vec(i);

    // aborted run: previous results hold, no done for the aborted run
    base = done_cnt;
    do_start(2'b11, 20, 100);
    feed(1, 50, 0);
    check("abort_hold_chi", chi_sum, 1024);
    check("abort_hold_pb", pass_block, 1);
    run_vec(0);
    check("abort_single_done", done_cnt, base + 1);

    // reset in the middle of COLLECT
    do_start(2'b11, 20, 100);
    feed(1, 30, 0);
    base = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_ready", bit_ready, 0);
    check("midrst_s_abs", s_abs, 0);
    check("midrst_chi_sum", chi_sum, 0);
    check("midrst_pass", {pass_mono, pass_block}, 0);
    repeat (20) tick();
    check("midrst_no_done", done_cnt, base);
    run_vec(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
